int_to_flp_seq: RTL and testbench

- Iterative converter from a signed two's-complement integer to an IEEE-754 single-precision value.
- This is the reverse path of the FLP_TO_DECIMAL datapath. It feeds decimal/integer results back into the floating-point domain.
- The magnitude is normalized with a one-bit-per-cycle left shift and rounded to nearest-even.
- The block uses a valid/ready handshake on both sides and holds one conversion in flight at a time.

---
 rtl/flp_pkg.sv | 26 ++
 rtl/flp_round_rne.sv | 41 ++++
 rtl/int_to_flp_seq.sv | 144 ++++++++++++++
 tb/tb_int_to_flp_seq.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/flp_pkg.sv
// rtl/flp_pkg.sv - shared single-precision float constants and types
//
// Purpose: constants, the packed float word layout and the converter state
// encoding shared by the integer-to-float path and its rounding helper.
// Ports: none (package).
package flp_pkg;

  localparam int INT_W    = 32;
  localparam int EXP_BIAS = 127;
  localparam int MANT_W   = 23;
  localparam int EXP_W    = 8;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
  } flp32_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_NORM  = 2'd1,
    ST_ROUND = 2'd2,
    ST_OUT   = 2'd3
  } conv_state_t;

endpackage

// File: rtl/flp_round_rne.sv
// rtl/flp_round_rne.sv - round-to-nearest-even of a normalized magnitude
//
// Purpose: combinational rounding of a left-normalized magnitude (implicit
// leading one already stripped) to a 23-bit mantissa, ties to even.
// Ports:
//   mag      in   31  magnitude bits below the leading one
//   exp_in   in    8  biased exponent before rounding
//   mant     out  23  rounded stored mantissa
//   exp_out  out   8  biased exponent after rounding
module flp_round_rne
  import flp_pkg::*;
(
  input  logic [30:0]        mag,
  input  logic [EXP_W-1:0]   exp_in,
  output logic [MANT_W-1:0]  mant,
  output logic [EXP_W-1:0]   exp_out
);

  logic [MANT_W-1:0] trunc;
  logic              guard;
  logic              sticky;
  logic              round_up;
  logic [MANT_W:0]   sum;

  assign trunc    = mag[30:8];
  assign guard    = mag[7];
  assign sticky   = |mag[6:0];
  assign round_up = guard & (sticky | trunc[0]);
  assign sum      = {1'b0, trunc} + (MANT_W+1)'(round_up);

  // A carry out of the mantissa means 1.111..1 rounded to 10.000..0:
  // the stored bits are already zero, only the exponent moves.
  always_comb begin
    mant    = sum[MANT_W-1:0];
    exp_out = exp_in;
    if (sum[MANT_W]) begin
      exp_out = exp_in + EXP_W'(1);
    end
  end

endmodule

// File: rtl/int_to_flp_seq.sv
// rtl/int_to_flp_seq.sv - iterative signed integer to single-precision float
//
// Purpose: converts one signed 32-bit integer at a time to IEEE-754 single,
// normalizing one bit per cycle and rounding to nearest-even.
// Ports:
//   clk        in    1  rising-edge clock
//   rst        in    1  asynchronous active-high reset
//   in_valid   in    1  in_data is valid
//   in_ready   out   1  accepting input (IDLE only)
//   in_data    in   32  signed two's-complement integer
//   out_valid  out   1  out_flp is valid
//   out_ready  in    1  consumer accepts out_flp
//   out_flp    out  32  {sign, exponent, mantissa}
//   busy       out   1  conversion in flight (any state but IDLE)
module int_to_flp_seq
  import flp_pkg::*;
#(
  parameter int INT_W    = 32,
  parameter int EXP_BIAS = 127,
  parameter int MANT_W   = 23,
  parameter int EXP_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [INT_W-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_flp,
  output logic             busy
);

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_NORM  = ST_NORM;
  localparam logic [1:0] S_ROUND = ST_ROUND;
  localparam logic [1:0] S_OUT   = ST_OUT;

  // Exponent of a magnitude whose leading one sits at bit INT_W-1.
  localparam logic [EXP_W-1:0] EXP_TOP = EXP_W'(EXP_BIAS + INT_W - 1);

  logic [1:0]        state_q, state_d;
  logic              sign_q, sign_d;
  logic [INT_W-1:0]  mag_q, mag_d;
  logic [EXP_W-1:0]  exp_q, exp_d;
  flp32_t            out_flp_q, out_flp_d;
  logic              out_valid_q, out_valid_d;

  logic [INT_W-1:0]  neg_data;
  logic [INT_W-1:0]  in_mag;
  logic [INT_W-1:0]  mag_shl;
  logic [MANT_W-1:0] rnd_mant;
  logic [EXP_W-1:0]  rnd_exp;

  // Two's-complement negate through the adder; -2^31 maps onto itself,
  // which read as unsigned is exactly the magnitude 2^31.
  assign neg_data = ~in_data + INT_W'(1);
  assign in_mag   = in_data[INT_W-1] ? neg_data : in_data;
  assign mag_shl  = mag_q << 1;

  flp_round_rne u_round (
    .mag     (mag_q[30:0]),
    .exp_in  (exp_q),
    .mant    (rnd_mant),
    .exp_out (rnd_exp)
  );

  always_comb begin
    state_d     = state_q;
    sign_d      = sign_q;
    mag_d       = mag_q;
    exp_d       = exp_q;
    out_flp_d   = out_flp_q;
    out_valid_d = out_valid_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          sign_d = in_data[INT_W-1];
          mag_d  = in_mag;
          exp_d  = EXP_TOP;
          if (in_mag == '0) begin
            // Zero bypasses rounding; sign is dropped so there is no -0.
            out_flp_d = '0;
            state_d   = S_OUT;
          end else if (in_mag[INT_W-1]) begin
            state_d = S_ROUND;
          end else begin
            state_d = S_NORM;
          end
        end
      end
      S_NORM: begin
        mag_d = mag_shl;
        exp_d = exp_q - EXP_W'(1);
        if (mag_shl[INT_W-1]) begin
          state_d = S_ROUND;
        end
      end
      S_ROUND: begin
        out_flp_d.sign = sign_q;
        out_flp_d.exp  = rnd_exp;
        out_flp_d.mant = rnd_mant;
        state_d        = S_OUT;
      end
      S_OUT: begin
        // out_valid is registered, so it rises one cycle after OUT is entered.
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      sign_q      <= 1'b0;
      mag_q       <= '0;
      exp_q       <= '0;
      out_flp_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sign_q      <= sign_d;
      mag_q       <= mag_d;
      exp_q       <= exp_d;
      out_flp_q   <= out_flp_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = out_valid_q;
  assign out_flp   = out_flp_q;

endmodule

// File: tb/tb_int_to_flp_seq.sv
// tb/tb_int_to_flp_seq.sv - randomized self-checking bench for int_to_flp_seq
module tb_int_to_flp_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_flp;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  int_to_flp_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_flp   (out_flp),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Reference: exact integer magnitude, leading-one position, then
  // round-half-to-even on the discarded remainder.
  task automatic model(input logic [31:0] v, output logic [31:0] f, output int lat);
    logic [63:0] m, q, rem, half;
    int          p, sh;
    logic        sgn;
    sgn = v[31];
    m   = sgn ? (64'h1_0000_0000 - {32'h0, v}) : {32'h0, v};
    if (m == 0) begin
      f   = 32'h0;
      lat = 1;
      return;
    end
    p = 0;
    for (int i = 0; i < 32; i++) if (m >= (64'd1 << i)) p = i;
    lat = (31 - p) + 2;
    if (p <= 23) begin
      q = m << (23 - p);
    end else begin
      sh   = p - 23;
      q    = m >> sh;
      rem  = m - (q << sh);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 1;
      if (q == (64'd1 << 24)) begin
        q = q >> 1;
        p = p + 1;
      end
    end
    f = {sgn, 8'(127 + p), q[22:0]};
  endtask

  task automatic run_conv(input logic [31:0] v, input int stall, input bit use_exp, input logic [31:0] exp_f);
    logic [31:0] ref_f;
    int          ref_lat;
    int          lat;
    model(v, ref_f, ref_lat);
    if (use_exp) ref_f = exp_f;
    out_ready = (stall == 0);
    check("in_ready_before", in_ready, 1);
    in_valid = 1'b1;
    in_data  = v;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = $urandom;
    check("busy_after_accept", busy, 1);
    lat = 0;
    while (!out_valid && lat < 40) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = $urandom;
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, ref_lat);
    check("out_flp", out_flp, ref_f);
    for (int c = 0; c < stall; c++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = $urandom;
      @(posedge clk); #1;
      check("stall_valid", out_valid, 1);
      check("stall_flp", out_flp, ref_f);
      check("stall_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("post_hs_valid", out_valid, 0);
    check("post_hs_in_ready", in_ready, 1);
    check("post_hs_busy", busy, 0);
  endtask

  typedef struct {
    logic [31:0] v;
    logic [31:0] f;
  } dir_t;

  dir_t dir_tab[7] = '{
    '{32'h0000_0001, 32'h3F80_0000},
    '{32'hFFFF_FFFF, 32'hBF80_0000},
    '{32'h8000_0000, 32'hCF00_0000},
    '{32'h0000_0000, 32'h0000_0000},
    '{32'd16777217,  32'h4B80_0000},
    '{32'd16777219,  32'h4B80_0002},
    '{32'h7FFF_FFFF, 32'h4F00_0000}
  };

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 32'h0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_flp", out_flp, 32'h0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    rst = 1'b0;
    @(posedge clk); #1;

    foreach (dir_tab[i]) run_conv(dir_tab[i].v, 0, 1'b1, dir_tab[i].f);

    run_conv(32'd5, 10, 1'b1, 32'h40A0_0000);

    // Abort a conversion deep in normalization.
    in_valid = 1'b1;
    in_data  = 32'd1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_in_ready", in_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("abort_still_idle", out_valid, 0);
    run_conv(32'd3, 0, 1'b1, 32'h4040_0000);

    for (int n = 0; n < 60; n++) begin
      v = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) v = -v;
      run_conv(v, $urandom_range(0, 3), 1'b0, 32'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
